// File: rtl/secondary_input_rx.sv
// Receiver for a streamed operand pair (r, t) plus n0'. Words arrive MSW first
// and are committed to the outputs only when a full transfer completes.
module secondary_input_rx #(
  parameter int WORD_W  = 32,
  parameter int WORDS   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_transfer,
  input  logic                     word_valid,
  input  logic [WORD_W-1:0]        r_word,
  input  logic [WORD_W-1:0]        t_word,
  input  logic [WORD_W-1:0]        n0p_in,
  output logic [WORD_W*WORDS-1:0]  r,
  output logic [WORD_W*WORDS-1:0]  t,
  output logic [WORD_W-1:0]        n0p,
  output logic                     busy,
  output logic                     done,
  output logic                     error
);

  // state   | meaning
  // IDLE    | waiting for start_transfer; word_valid ignored
  // COLLECT | shifting words into the shadows, idle timer running

  localparam int OP_W   = WORD_W * WORDS;
  localparam int CNT_W  = $clog2(WORDS + 1);
  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WORDS - 1);
  localparam logic [IDLE_W-1:0] TO_LAST  = IDLE_W'(TIMEOUT - 1);
  localparam logic [IDLE_W-1:0] TO_MAX   = IDLE_W'(TIMEOUT);

  typedef enum logic {S_IDLE = 1'b0, S_COLLECT = 1'b1} state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    word_cnt;
  logic [IDLE_W-1:0]   idle_cnt;
  logic [OP_W-1:0]     shadow_r, shadow_t;
  logic [WORD_W-1:0]   shadow_n0p;
  logic                accept, last_word, timeout_hit;

  // A restart always wins over a word or a timeout in the same cycle.
  assign accept      = (state == S_COLLECT) && !start_transfer && word_valid;
  assign last_word   = accept && (word_cnt == LAST_CNT);
  assign timeout_hit = (state == S_COLLECT) && !start_transfer && !word_valid &&
                       (idle_cnt >= TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start_transfer) state_nxt = S_COLLECT;
      S_COLLECT: begin
        if (start_transfer)                state_nxt = S_COLLECT;
        else if (last_word || timeout_hit) state_nxt = S_IDLE;
      end
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_COLLECT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done  <= 1'b0;
      error <= 1'b0;
    end else begin
      done  <= last_word;
      error <= timeout_hit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt   <= '0;
      idle_cnt   <= '0;
      shadow_r   <= '0;
      shadow_t   <= '0;
      shadow_n0p <= '0;
      r          <= '0;
      t          <= '0;
      n0p        <= '0;
    end else if (start_transfer) begin
      word_cnt   <= '0;
      idle_cnt   <= '0;
      shadow_r   <= '0;
      shadow_t   <= '0;
      shadow_n0p <= n0p_in;
    end else if (accept) begin
      shadow_r <= {shadow_r[OP_W-WORD_W-1:0], r_word};
      shadow_t <= {shadow_t[OP_W-WORD_W-1:0], t_word};
      word_cnt <= word_cnt + 1'b1;
      idle_cnt <= '0;
      if (last_word) begin
        r   <= {shadow_r[OP_W-WORD_W-1:0], r_word};
        t   <= {shadow_t[OP_W-WORD_W-1:0], t_word};
        n0p <= shadow_n0p;
      end
    end else if (state == S_COLLECT) begin
      if (idle_cnt != TO_MAX) idle_cnt <= idle_cnt + 1'b1;
      if (timeout_hit) begin
        shadow_r <= '0;
        shadow_t <= '0;
      end
    end
  end

endmodule

// File: tb/tb_secondary_input_rx.sv
// Directed bench for secondary_input_rx: expected done/error events are queued
// by the stimulus and checked by an independent monitor.
module tb_secondary_input_rx;

  localparam int WORD_W = 32;
  localparam int WORDS  = 32;
  localparam int OP_W   = WORD_W * WORDS;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start_transfer = 1'b0;
  logic              word_valid = 1'b0;
  logic [WORD_W-1:0] r_word = '0, t_word = '0, n0p_in = '0;
  logic [OP_W-1:0]   r, t;
  logic [WORD_W-1:0] n0p;
  logic              busy, done, error;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit              is_err;
    logic [OP_W-1:0] r;
    logic [OP_W-1:0] t;
    logic [31:0]     n0p;
  } exp_t;

  exp_t q[$];
  logic [OP_W-1:0] cur_r = '0, cur_t = '0;
  logic [31:0]     cur_n0p = '0;

  secondary_input_rx #(.WORD_W(WORD_W), .WORDS(WORDS), .TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n), .start_transfer(start_transfer),
    .word_valid(word_valid), .r_word(r_word), .t_word(t_word), .n0p_in(n0p_in),
    .r(r), .t(t), .n0p(n0p), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  function automatic logic [OP_W-1:0] exp_vec(input logic [31:0] base, input bit inv);
    logic [OP_W-1:0] v;
    logic [31:0]     w;
    v = '0;
    for (int k = 0; k < WORDS; k++) begin
      w = base + 32'(k);
      v[OP_W-1-k*WORD_W -: WORD_W] = inv ? ~w : w;
    end
    return v;
  endfunction

  function automatic int first_diff(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b);
    for (int k = 0; k < WORDS; k++)
      if (a[OP_W-1-k*WORD_W -: WORD_W] !== b[OP_W-1-k*WORD_W -: WORD_W]) return k;
    return -1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic chk_op(input string name, input logic [OP_W-1:0] act, input logic [OP_W-1:0] req);
    int k;
    checks++;
    k = first_diff(act, req);
    if (k >= 0) begin
      errors++;
      $display("FAIL %s: word %0d got %h expected %h", name, k,
               act[OP_W-1-k*WORD_W -: WORD_W], req[OP_W-1-k*WORD_W -: WORD_W]);
    end
  endtask

  // Monitor: every done/error pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && (done || error)) begin
      exp_t e;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got done=%b error=%b expected none", done, error);
      end else begin
        e = q.pop_front();
        chk("pulse_kind", {62'b0, done, error}, {62'b0, !e.is_err, e.is_err});
        chk_op("out_r", r, e.r);
        chk_op("out_t", t, e.t);
        chk("out_n0p", 64'(n0p), 64'(e.n0p));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [31:0] v);
    start_transfer = 1'b1;
    n0p_in = v;
    cyc();
    start_transfer = 1'b0;
  endtask

  task automatic word(input logic [31:0] rw, input logic [31:0] tw);
    word_valid = 1'b1;
    r_word = rw;
    t_word = tw;
    cyc();
    word_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic expect_done(input logic [OP_W-1:0] er, input logic [OP_W-1:0] et,
                             input logic [31:0] en);
    q.push_back('{1'b0, er, et, en});
    cur_r = er;
    cur_t = et;
    cur_n0p = en;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  int gap_at[10]  = '{3, 7, 10, 12, 15, 18, 21, 25, 28, 31};
  int gap_len[10] = '{1, 5, 63, 2, 10, 1, 30, 7, 4, 63};

  initial begin
    int g;
    #2;
    chk("rst_r", 64'(r[63:0]), 64'd0);
    chk("rst_n0p", 64'(n0p), 64'd0);
    chk("rst_flags", {61'b0, busy, done, error}, 64'd0);
    chk("rst_zero", 64'(r != '0 || t != '0), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Plain transfer, then back-to-back restart in the done cycle.
    start(32'hDEADBEEF);
    chk("busy_collect", 64'(busy), 64'd1);
    for (int k = 0; k < WORDS; k++) begin
      if (k == WORDS - 1) expect_done(exp_vec(0, 0), exp_vec(0, 1), 32'hDEADBEEF);
      word(32'(k), ~32'(k));
    end
    chk("done_cycle_busy", 64'(busy), 64'd0);
    chk("r_msw", 64'(r[1023:992]), 64'd0);
    chk("r_lsw", 64'(r[31:0]), 64'd31);
    chk("t_lsw", 64'(t[31:0]), 64'hFFFFFFE0);
    chk("n0p_t1", 64'(n0p), 64'hDEADBEEF);

    // Same transfer with gaps, including two of the longest legal length.
    start(32'hDEADBEEF);
    g = 0;
    for (int k = 0; k < WORDS; k++) begin
      if (g < 10 && gap_at[g] == k) begin
        idle(gap_len[g]);
        g++;
      end
      if (k == WORDS - 1) expect_done(exp_vec(0, 0), exp_vec(0, 1), 32'hDEADBEEF);
      word(32'(k), ~32'(k));
    end
    idle(2);

    // Abort by timeout after 5 words: outputs keep previous values.
    start(32'h12345678);
    for (int k = 0; k < 5; k++) word(32'hAAAA0000 + 32'(k), 32'h5555);
    q.push_back('{1'b1, cur_r, cur_t, cur_n0p});
    idle(64);
    chk("abort_busy", 64'(busy), 64'd0);
    idle(2);

    // Restart after 20 words, with a word_valid coincident with the restart.
    start(32'h00000055);
    for (int k = 0; k < 20; k++) word(32'hA0000000 + 32'(k), 32'hB0000000 + 32'(k));
    chk_op("hold_r_collect", r, cur_r);
    word_valid = 1'b1;
    r_word = 32'hBAD;
    t_word = 32'hBAD;
    start(32'h1);
    for (int k = 0; k < WORDS; k++) begin
      if (k == WORDS - 1) expect_done(exp_vec(32'h100, 0), exp_vec(32'h200, 0), 32'h1);
      word(32'h100 + 32'(k), 32'h200 + 32'(k));
    end
    idle(2);

    // Restart coincident with the final word: no completion.
    start(32'h77);
    for (int k = 0; k < WORDS - 1; k++) word(32'hC0 + 32'(k), 32'hD0 + 32'(k));
    word_valid = 1'b1;
    r_word = 32'hEE;
    t_word = 32'hEE;
    start(32'h88);
    chk("restart_busy", 64'(busy), 64'd1);
    for (int k = 0; k < WORDS; k++) begin
      if (k == WORDS - 1) expect_done(exp_vec(32'h300, 0), exp_vec(32'h400, 1), 32'h88);
      word(32'h300 + 32'(k), ~(32'h400 + 32'(k)));
    end
    idle(2);

    // Reset after word 16 clears everything; nothing follows release.
    start(32'h99);
    for (int k = 0; k <= 16; k++) word(32'hF0 + 32'(k), 32'hF1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", 64'(busy), 64'd0);
    chk("async_rst_zero", 64'(r != '0 || t != '0 || n0p != '0), 64'd0);
    cyc();
    rst_n = 1'b1;
    cur_r = '0;
    cur_t = '0;
    cur_n0p = '0;
    idle(5);
    chk("post_rst_flags", {61'b0, busy, done, error}, 64'd0);
    start(32'hDEADBEEF);
    for (int k = 0; k < WORDS; k++) begin
      if (k == WORDS - 1) expect_done(exp_vec(0, 0), exp_vec(0, 1), 32'hDEADBEEF);
      word(32'(k), ~32'(k));
    end

    // 33rd word and IDLE word_valid pulses are ignored.
    word(32'h12121212, 32'h34343434);
    idle(2);
    for (int i = 0; i < 3; i++) begin
      word(32'h5A5A0000 + 32'(i), 32'hA5A5);
      idle(1);
    end
    chk("idle_busy", 64'(busy), 64'd0);
    chk_op("idle_r_stable", r, exp_vec(0, 0));
    chk_op("idle_t_stable", t, exp_vec(0, 1));
    chk("idle_n0p_stable", 64'(n0p), 64'hDEADBEEF);

    idle(5);
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
